// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the CPU-side memory interface.
// Holds the loader FSM encoding and the memory read/write strobe polarity.
// The helper functions classify states so the top stays free of repeated lists.
package program_loader_pkg;

   // Loader FSM states, in stream order
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LEN_HI  = 4'd1,
      LEN_LO  = 4'd2,
      DATA_HI = 4'd3,
      DATA_LO = 4'd4,
      WRITE   = 4'd5,
      CHK     = 4'd6,
      DONE    = 4'd7,
      ERROR   = 4'd8
   } state_t;

   // MemRW polarity, identical to the CPU controller's encoding
   localparam logic MEM_WRITE = 1'b1;
   localparam logic MEM_READ  = 1'b0;

   // States in which one stream byte may be consumed
   function automatic logic takes_byte(input state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
             (s == DATA_LO) || (s == CHK);
   endfunction

   // States from which a Start request begins a new load
   function automatic logic can_start(input state_t s);
      return (s == IDLE) || (s == DONE) || (s == ERROR);
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream plus instruction-memory write port of the program loader.
// master = the loader (drives ByteReady and the memory write bus);
// slave  = the environment (byte source and memory).
interface program_loader_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [7:0]            ByteIn;
   logic                  ByteValid;
   logic                  ByteReady;
   logic [ADDR_WIDTH-1:0] MemAddr;
   logic [15:0]           MemData;
   logic                  MemRW;

   modport master (
      input  ByteIn,
      input  ByteValid,
      output ByteReady,
      output MemAddr,
      output MemData,
      output MemRW
   );

   modport slave (
      output ByteIn,
      output ByteValid,
      input  ByteReady,
      input  MemAddr,
      input  MemData,
      input  MemRW
   );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory, then releases CPU reset.
// Latency: a write strobe follows the edge accepting DATA_LO; Done/Error follow the edge accepting CHK.
// Backpressure: ByteReady is low while writing and outside a load; bytes wait indefinitely (no timeout).
module program_loader
   import program_loader_pkg::*;
#(
   parameter int          ADDR_WIDTH = 16,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned MAX_WORDS  = 256
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   program_loader_if.master    bus,
   output logic                CPUReset_n,
   output logic                Busy,
   output logic                Done,
   output logic                Error,
   output logic [15:0]         WordCount
);

   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(START_ADDR);

   state_t      state_q;
   state_t      state_d;

   // datapath registers
   logic [7:0]  len_hi_q;
   logic [15:0] len_q;
   logic [7:0]  data_hi_q;
   logic [7:0]  chk_q;

   // next values of the registered outputs, decoded from the next state
   logic        byte_ready_d;
   logic        mem_rw_d;
   logic        busy_d;
   logic        done_d;
   logic        error_d;
   logic        cpu_reset_n_d;

   logic        accept;
   logic        start_load;
   logic [15:0] len_word;
   logic [15:0] word_count_inc;

   assign accept         = bus.ByteValid && bus.ByteReady;
   assign start_load     = Start && can_start(state_q);
   assign len_word       = {len_hi_q, bus.ByteIn};
   assign word_count_inc = WordCount + 16'd1;

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: advance on accepted bytes, WRITE always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE, ERROR: begin
            if (Start) state_d = LEN_HI;
         end
         LEN_HI: begin
            if (accept) state_d = LEN_LO;
         end
         LEN_LO: begin
            if (accept) begin
               if (32'(len_word) > MAX_WORDS) state_d = ERROR;
               else if (len_word == 16'd0)    state_d = CHK;
               else                           state_d = DATA_HI;
            end
         end
         DATA_HI: begin
            if (accept) state_d = DATA_LO;
         end
         DATA_LO: begin
            if (accept) state_d = WRITE;
         end
         WRITE: begin
            if (word_count_inc == len_q) state_d = CHK;
            else                         state_d = DATA_HI;
         end
         CHK: begin
            if (accept) state_d = (bus.ByteIn == chk_q) ? DONE : ERROR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so the outputs can be registered without a cycle of lag
   always_comb begin
      byte_ready_d  = takes_byte(state_d);
      mem_rw_d      = (state_d == WRITE) ? MEM_WRITE : MEM_READ;
      busy_d        = !can_start(state_d);
      done_d        = (state_d == DONE);
      error_d       = (state_d == ERROR);
      cpu_reset_n_d = (state_d == DONE);
   end

   // Registered control outputs; reset forces MemRW low at once, so no strobe survives it
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         bus.ByteReady <= 1'b0;
         bus.MemRW     <= MEM_READ;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Error         <= 1'b0;
         CPUReset_n    <= 1'b0;
      end else begin
         bus.ByteReady <= byte_ready_d;
         bus.MemRW     <= mem_rw_d;
         Busy          <= busy_d;
         Done          <= done_d;
         Error         <= error_d;
         CPUReset_n    <= cpu_reset_n_d;
      end
   end

   // Datapath: length capture, word assembly, checksum fold, write address/data and word count
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         len_hi_q    <= 8'd0;
         len_q       <= 16'd0;
         data_hi_q   <= 8'd0;
         chk_q       <= 8'd0;
         WordCount   <= 16'd0;
         bus.MemAddr <= BASE_ADDR;
         bus.MemData <= 16'd0;
      end else begin
         if (start_load) begin
            chk_q     <= 8'd0;
            WordCount <= 16'd0;
         end
         if (accept) begin
            case (state_q)
               LEN_HI: len_hi_q <= bus.ByteIn;
               LEN_LO: len_q    <= len_word;
               DATA_HI: begin
                  data_hi_q <= bus.ByteIn;
                  chk_q     <= chk_q ^ bus.ByteIn;
               end
               DATA_LO: begin
                  chk_q       <= chk_q ^ bus.ByteIn;
                  bus.MemData <= {data_hi_q, bus.ByteIn};
                  // address wraps modulo 2^ADDR_WIDTH
                  bus.MemAddr <= BASE_ADDR + ADDR_WIDTH'(WordCount);
               end
               default: ;
            endcase
         end
         if (state_q == WRITE) begin
            WordCount <= word_count_inc;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good, bad, empty and oversize loads,
// stalled byte streams, Start while busy, restart from DONE/ERROR and mid-load reset.
module tb_program_loader;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic        CPUReset_n;
   logic        Busy;
   logic        Done;
   logic        Error;
   logic [15:0] WordCount;

   int checks;
   int errors;

   program_loader_if #(.ADDR_WIDTH(16)) bus ();

   program_loader #(
      .ADDR_WIDTH(16),
      .START_ADDR(0),
      .MAX_WORDS (256)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .bus       (bus),
      .CPUReset_n(CPUReset_n),
      .Busy      (Busy),
      .Done      (Done),
      .Error     (Error),
      .WordCount (WordCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Write monitor: records every strobe seen at the falling edge and counts strobes longer than one cycle
   logic [15:0] wr_addr [$];
   logic [15:0] wr_data [$];
   int          wide_pulses;
   logic        prev_rw;

   always @(negedge Clock) begin
      if (bus.MemRW === 1'b1) begin
         wr_addr.push_back(bus.MemAddr);
         wr_data.push_back(bus.MemData);
         if (prev_rw === 1'b1) wide_pulses++;
      end
      prev_rw = bus.MemRW;
   end

   task automatic clear_writes();
      wr_addr.delete();
      wr_data.delete();
      wide_pulses = 0;
   endtask

   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   // Sends n bytes MSB-first from data; byte i is preceded by (i*3) % (max_gap+1) idle cycles.
   // Entered and left just after a falling edge.
   task automatic send_stream(input logic [63:0] data, input int n, input int max_gap);
      int waited;
      for (int i = 0; i < n; i++) begin
         bus.ByteValid = 1'b0;
         repeat ((i * 3) % (max_gap + 1)) @(negedge Clock);
         bus.ByteIn    = data[8*(n-1-i) +: 8];
         bus.ByteValid = 1'b1;
         waited = 0;
         while (bus.ByteReady !== 1'b1 && waited < 50) begin
            @(negedge Clock);
            waited++;
         end
         if (bus.ByteReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout byte %0d ByteReady=%b never rose within 50 cycles", i, bus.ByteReady);
            bus.ByteValid = 1'b0;
            return;
         end
         @(negedge Clock);
      end
      bus.ByteValid = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      Start = 1'b0;
      bus.ByteValid = 1'b0;
      bus.ByteIn = 8'h00;
      clear_writes();
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      repeat (5) @(negedge Clock);
      checks++; if (bus.ByteReady !== 1'b0) begin errors++; $display("FAIL rst_byte_ready got %b want 0", bus.ByteReady); end
      checks++; if (bus.MemAddr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got %h want 0000", bus.MemAddr); end
      checks++; if (bus.MemData !== 16'h0000) begin errors++; $display("FAIL rst_mem_data got %h want 0000", bus.MemData); end
      checks++; if (bus.MemRW !== 1'b0) begin errors++; $display("FAIL rst_mem_rw got %b want 0", bus.MemRW); end
      checks++; if (CPUReset_n !== 1'b0) begin errors++; $display("FAIL rst_cpu_reset_n got %b want 0", CPUReset_n); end
      checks++; if ({Busy, Done, Error} !== 3'b000) begin errors++; $display("FAIL rst_status got %b want 000", {Busy, Done, Error}); end
      checks++; if (WordCount !== 16'd0) begin errors++; $display("FAIL rst_word_count got %0d want 0", WordCount); end
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL rst_no_write got %0d writes want 0", wr_addr.size()); end
   endtask

   task automatic test_good_load();
      clear_writes();
      pulse_start();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL good_busy got %b want 1", Busy); end
      checks++; if (bus.ByteReady !== 1'b1) begin errors++; $display("FAIL good_ready got %b want 1", bus.ByteReady); end
      send_stream(64'h0002_1234_ABCD_40, 7, 0);
      checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL good_write_count got %0d want 2", wr_addr.size()); end
      checks++; if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 16'h1234) begin errors++; $display("FAIL good_write0 got %h@%h want 1234@0000", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 16'h0001 || wr_data[1] !== 16'hABCD) begin errors++; $display("FAIL good_write1 got %h@%h want abcd@0001", wr_data[1], wr_addr[1]); end
      checks++; if (wide_pulses != 0) begin errors++; $display("FAIL good_pulse_width got %0d long strobes want 0", wide_pulses); end
      checks++; if ({Busy, Done, Error} !== 3'b010) begin errors++; $display("FAIL good_status got %b want 010", {Busy, Done, Error}); end
      checks++; if (CPUReset_n !== 1'b1) begin errors++; $display("FAIL good_cpu_reset_n got %b want 1", CPUReset_n); end
      checks++; if (WordCount !== 16'd2) begin errors++; $display("FAIL good_word_count got %0d want 2", WordCount); end
      checks++; if (bus.ByteReady !== 1'b0) begin errors++; $display("FAIL good_ready_after got %b want 0", bus.ByteReady); end
   endtask

   task automatic test_bad_checksum();
      clear_writes();
      pulse_start();
      // restart from DONE drops CPU reset on the Start edge
      checks++; if (CPUReset_n !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL restart_done got cpu_rst_n=%b done=%b want 0 0", CPUReset_n, Done); end
      checks++; if (WordCount !== 16'd0) begin errors++; $display("FAIL restart_word_count got %0d want 0", WordCount); end
      send_stream(64'h0002_1234_ABCD_41, 7, 0);
      checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL bad_write_count got %0d want 2", wr_addr.size()); end
      checks++; if ({Busy, Done, Error} !== 3'b001) begin errors++; $display("FAIL bad_status got %b want 001", {Busy, Done, Error}); end
      checks++; if (CPUReset_n !== 1'b0) begin errors++; $display("FAIL bad_cpu_reset_n got %b want 0", CPUReset_n); end
      clear_writes();
      pulse_start();
      checks++; if ({Busy, Error} !== 2'b10) begin errors++; $display("FAIL restart_error got busy/err %b want 10", {Busy, Error}); end
      send_stream(64'h0002_1234_ABCD_40, 7, 0);
      checks++; if ({Busy, Done, Error} !== 3'b010 || CPUReset_n !== 1'b1) begin errors++; $display("FAIL reload_status got %b cpu_rst_n=%b want 010 1", {Busy, Done, Error}, CPUReset_n); end
      checks++; if (wr_data[1] !== 16'hABCD) begin errors++; $display("FAIL reload_write1 got %h want abcd", wr_data[1]); end
   endtask

   task automatic test_zero_len();
      clear_writes();
      pulse_start();
      send_stream(64'h0000_00, 3, 0);
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL zero_write_count got %0d want 0", wr_addr.size()); end
      checks++; if ({Busy, Done, Error} !== 3'b010 || CPUReset_n !== 1'b1) begin errors++; $display("FAIL zero_status got %b cpu_rst_n=%b want 010 1", {Busy, Done, Error}, CPUReset_n); end
      checks++; if (WordCount !== 16'd0) begin errors++; $display("FAIL zero_word_count got %0d want 0", WordCount); end
   endtask

   task automatic test_too_long();
      clear_writes();
      pulse_start();
      send_stream(64'h0101, 2, 0);
      checks++; if ({Busy, Done, Error} !== 3'b001) begin errors++; $display("FAIL long_status got %b want 001", {Busy, Done, Error}); end
      checks++; if (bus.ByteReady !== 1'b0) begin errors++; $display("FAIL long_ready got %b want 0", bus.ByteReady); end
      // further valid bytes are ignored while not ready
      bus.ByteIn = 8'h12;
      bus.ByteValid = 1'b1;
      repeat (4) @(negedge Clock);
      bus.ByteValid = 1'b0;
      checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL long_no_write got %0d writes want 0", wr_addr.size()); end
      checks++; if (Error !== 1'b1 || CPUReset_n !== 1'b0) begin errors++; $display("FAIL long_sticky got err=%b cpu_rst_n=%b want 1 0", Error, CPUReset_n); end
   endtask

   task automatic test_gaps();
      clear_writes();
      pulse_start();
      send_stream(64'h0002, 2, 3);
      // Start while busy must be ignored
      pulse_start();
      checks++; if (Busy !== 1'b1 || bus.ByteReady !== 1'b1) begin errors++; $display("FAIL busy_start got busy=%b ready=%b want 1 1", Busy, bus.ByteReady); end
      send_stream(64'h1234_ABCD_40, 5, 4);
      checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL gap_write_count got %0d want 2", wr_addr.size()); end
      checks++; if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 16'h1234) begin errors++; $display("FAIL gap_write0 got %h@%h want 1234@0000", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 16'h0001 || wr_data[1] !== 16'hABCD) begin errors++; $display("FAIL gap_write1 got %h@%h want abcd@0001", wr_data[1], wr_addr[1]); end
      checks++; if ({Busy, Done, Error} !== 3'b010 || WordCount !== 16'd2) begin errors++; $display("FAIL gap_status got %b wc=%0d want 010 2", {Busy, Done, Error}, WordCount); end
      // ByteValid while not ready (DONE) has no effect
      bus.ByteIn = 8'h55;
      bus.ByteValid = 1'b1;
      repeat (5) @(negedge Clock);
      bus.ByteValid = 1'b0;
      checks++; if (Done !== 1'b1 || WordCount !== 16'd2 || wr_addr.size() != 2) begin errors++; $display("FAIL done_idle_bytes got done=%b wc=%0d writes=%0d want 1 2 2", Done, WordCount, wr_addr.size()); end
   endtask

   task automatic test_reset_mid_load();
      clear_writes();
      pulse_start();
      send_stream(64'h0002_1234_AB, 5, 0);
      checks++; if (WordCount !== 16'd1) begin errors++; $display("FAIL mid_word_count_before got %0d want 1", WordCount); end
      // present DATA_LO of word 1 and pull reset at the same time
      bus.ByteIn = 8'hCD;
      bus.ByteValid = 1'b1;
      Reset = 1'b0;
      #1;
      checks++; if (bus.MemRW !== 1'b0 || bus.ByteReady !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got rw=%b ready=%b want 0 0", bus.MemRW, bus.ByteReady); end
      checks++; if (WordCount !== 16'd0 || bus.MemAddr !== 16'h0000 || bus.MemData !== 16'h0000) begin errors++; $display("FAIL mid_rst_data got wc=%0d addr=%h data=%h want 0 0000 0000", WordCount, bus.MemAddr, bus.MemData); end
      checks++; if ({Busy, Done, Error} !== 3'b000 || CPUReset_n !== 1'b0) begin errors++; $display("FAIL mid_rst_status got %b cpu_rst_n=%b want 000 0", {Busy, Done, Error}, CPUReset_n); end
      @(negedge Clock);
      bus.ByteValid = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL mid_rst_no_strobe got %0d writes want 1", wr_addr.size()); end
      checks++; if (Busy !== 1'b0 || bus.ByteReady !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got busy=%b ready=%b want 0 0", Busy, bus.ByteReady); end
      clear_writes();
      pulse_start();
      checks++; if (WordCount !== 16'd0 || Busy !== 1'b1) begin errors++; $display("FAIL reload_start got wc=%0d busy=%b want 0 1", WordCount, Busy); end
      send_stream(64'h0001_BEEF_51, 5, 0);
      checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 16'h0000 || wr_data[0] !== 16'hBEEF) begin errors++; $display("FAIL reload_write got %0d writes %h@%h want 1 beef@0000", wr_addr.size(), wr_data[0], wr_addr[0]); end
      checks++; if ({Busy, Done, Error} !== 3'b010 || WordCount !== 16'd1 || CPUReset_n !== 1'b1) begin errors++; $display("FAIL reload_status got %b wc=%0d cpu_rst_n=%b want 010 1 1", {Busy, Done, Error}, WordCount, CPUReset_n); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      prev_rw = 1'b0;
      wide_pulses = 0;
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_zero_len();
      test_too_long();
      test_gaps();
      test_reset_mid_load();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
